instruction_prefetch_unit: RTL and testbench

//  Parametrised fetch stage with an in-order prefetch queue; successor to the single-PC IF stage.

---
 rtl/ipf_pkg.sv | 22 ++
 rtl/ipf_fifo.sv | 75 +++++++
 rtl/instruction_prefetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_instruction_prefetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipf_pkg.sv
// ----------------------------------------------------------------------------
// ipf_pkg
// Shared types and constants for the instruction prefetch unit.
//   addr_t / instr_t : default PC and instruction word types
//   fetch_entry_t    : one queue entry, a fetched word together with its PC
//   PC_STEP          : byte distance between sequential instructions
// ----------------------------------------------------------------------------
package ipf_pkg;

    localparam int IPF_ADDR_W  = 64;
    localparam int IPF_INSTR_W = 32;
    localparam int PC_STEP     = 4;

    typedef logic [IPF_ADDR_W-1:0]  addr_t;
    typedef logic [IPF_INSTR_W-1:0] instr_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/ipf_fifo.sv
// ----------------------------------------------------------------------------
// ipf_fifo
// Synchronous FIFO with flush, used both as the fetch queue and as the
// in-flight PC-tag store. The head entry is read straight from the storage
// registers, so a word pushed into an empty FIFO is visible one cycle later.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   push / wr_data    write request and entry (ignored when full)
//   pop               remove the head entry (ignored when empty)
//   flush             drop all entries; wins over push and pop
//   rd_data           head entry
//   full, empty       occupancy flags
//   count             number of stored entries, $clog2(DEPTH)+1 bits
// ----------------------------------------------------------------------------
module ipf_fifo
    import ipf_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   wr_data,
    output entry_t                   rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/instruction_prefetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_prefetch_unit
// Fetch stage with an in-order prefetch queue. Sequential PCs are requested
// from instruction memory, returned words are buffered with their PCs and
// handed to decode. A redirect flushes the queue and discards any responses
// that are still in flight.
// Ports:
//   clock, reset                  rising-edge clock, async active-low reset
//   imem_req_valid/ready/addr     fetch request channel (addr = fetch PC)
//   imem_rsp_valid/data           in-order responses, no backpressure
//   redirect_valid/redirect_pc    branch / BR / exception redirect
//   out_valid/ready               queue head handshake towards decode
//   out_instr, out_pc             head instruction and its PC
//   out_pc_link                   head PC + 4 (BL link value)
//   fault, fault_pc               sticky misaligned-redirect flag and target
//                                 (only with IPF_ALIGN_FAULT_EN defined)
// Configuration macro IPF_ALIGN_FAULT_EN: when defined, a misaligned redirect
// sets fault and halts fetch until reset; when undefined the two low bits of
// redirect_pc are ignored.
// ----------------------------------------------------------------------------
module instruction_prefetch_unit
    import ipf_pkg::*;
#(
    parameter int                ADDR_W   = IPF_ADDR_W,
    parameter int                INSTR_W  = IPF_INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
`ifdef IPF_ALIGN_FAULT_EN
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc,
`endif
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_link
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [ADDR_W-1:0] redirect_target;
    logic              fault_block;
    logic [CNT_W:0]    credit_used;
    logic              req_fire;
    logic              rsp_live;
    logic              rsp_keep;

    logic              queue_push, queue_pop, queue_full, queue_empty;
    logic [CNT_W-1:0]  queue_count;
    entry_t            queue_wdata, queue_rdata;

    logic [ADDR_W-1:0] tag_pc;
    logic              tag_full, tag_empty;
    logic [CNT_W-1:0]  tag_count;
    logic              unused_bits;

`ifdef IPF_ALIGN_FAULT_EN
    logic              fault_q;
    logic [ADDR_W-1:0] fault_pc_q;
    logic              fault_now;

    assign redirect_target = redirect_pc;
    assign fault_now       = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fault_block     = fault_q;

    // The first misaligned redirect is captured and held until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (fault_now && !fault_q) begin
            fault_q    <= 1'b1;
            fault_pc_q <= redirect_pc;
        end
    end

    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign unused_bits = ^{tag_full, tag_count};
`else
    assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign fault_block     = 1'b0;
    assign unused_bits     = ^{tag_full, tag_count, redirect_pc[1:0]};
`endif

    // Credit covers both buffered words and requests still in flight, so
    // every returning word is guaranteed a free queue slot.
    assign credit_used    = {1'b0, queue_count} + {1'b0, outstanding_q};
    assign imem_req_valid = reset && !redirect_valid && !fault_block
                            && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // With nothing outstanding a response can only be a leftover from
    // before a reset and is ignored entirely.
    assign rsp_live = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep = rsp_live && (discard_q == '0) && !redirect_valid
                      && !fault_block && !tag_empty;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        end
        // Every request still in flight after this cycle belongs to the
        // old path; recomputed on each redirect so the last one wins.
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            discard_d  = outstanding_q - CNT_W'(rsp_live);
        end else if (rsp_live && (discard_q != '0)) begin
            discard_d  = discard_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // PC of each live request, consumed when its word comes back.
    ipf_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (logic [ADDR_W-1:0])
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (req_fire),
        .pop     (rsp_keep),
        .flush   (redirect_valid),
        .wr_data (fetch_pc_q),
        .rd_data (tag_pc),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

    assign queue_push  = rsp_keep;
    assign queue_pop   = !queue_empty && out_ready;
    assign queue_wdata = '{pc: tag_pc, instr: imem_rsp_data};

    ipf_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clock   (clock),
        .reset   (reset),
        .push    (queue_push),
        .pop     (queue_pop),
        .flush   (redirect_valid),
        .wr_data (queue_wdata),
        .rd_data (queue_rdata),
        .full    (queue_full),
        .empty   (queue_empty),
        .count   (queue_count)
    );

    // Head fields read as zero while the queue is empty.
    assign out_valid   = !queue_empty;
    assign out_instr   = out_valid ? queue_rdata.instr : '0;
    assign out_pc      = out_valid ? queue_rdata.pc : '0;
    assign out_pc_link = out_valid ? (queue_rdata.pc + ADDR_W'(PC_STEP)) : '0;

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
`timescale 1ns/1ps
module tb_instruction_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [63:0] out_pc_link;

    // Second instance: starts near the top of the address space.
    logic        req2_valid;
    logic        req2_ready;
    logic [63:0] req2_addr;
    logic        rsp2_valid;
    logic [31:0] rsp2_data;
    logic        redir2_valid;
    logic [63:0] redir2_pc;
    logic        out2_valid;
    logic        out2_ready;
    logic [31:0] out2_instr;
    logic [63:0] out2_pc;
    logic [63:0] out2_pc_link;

`ifdef IPF_ALIGN_FAULT_EN
    logic        fault;
    logic [63:0] fault_pc;
    logic        fault2;
    logic [63:0] fault2_pc;
`endif

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int memLat   = 1;
    int reqCount = 0;
    int reqBase  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    instruction_prefetch_unit #(
        .DEPTH    (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
`ifdef IPF_ALIGN_FAULT_EN
        .fault          (fault),
        .fault_pc       (fault_pc),
`endif
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_link    (out_pc_link)
    );

    instruction_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (64'hFFFF_FFFF_FFFF_FFF8)
    ) dut2 (
        .clock          (clock),
        .reset          (reset),
`ifdef IPF_ALIGN_FAULT_EN
        .fault          (fault2),
        .fault_pc       (fault2_pc),
`endif
        .imem_req_valid (req2_valid),
        .imem_req_ready (req2_ready),
        .imem_req_addr  (req2_addr),
        .imem_rsp_valid (rsp2_valid),
        .imem_rsp_data  (rsp2_data),
        .redirect_valid (redir2_valid),
        .redirect_pc    (redir2_pc),
        .out_valid      (out2_valid),
        .out_ready      (out2_ready),
        .out_instr      (out2_instr),
        .out_pc         (out2_pc),
        .out_pc_link    (out2_pc_link)
    );

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] memWord(input logic [63:0] a);
        return {16'hC0DE ^ a[31:16] ^ a[47:32] ^ a[63:48], a[15:0]};
    endfunction

    // Main memory model: in-order responses memLat cycles after acceptance.
    typedef struct {
        int          due;
        logic [63:0] addr;
    } pend_t;
    pend_t pend[$];

    always @(negedge clock) begin
        if (!reset) begin
            pend.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{cyc + memLat, imem_req_addr});
            reqCount++;
        end
    end

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clock);
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memWord(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    // Second memory model: always ready, one cycle latency.
    logic        acc2  = 1'b0;
    logic [63:0] addr2 = '0;

    always @(negedge clock) begin
        acc2  = reset && req2_valid;
        addr2 = req2_addr;
    end

    initial begin
        rsp2_valid = 1'b0;
        rsp2_data  = '0;
        forever begin
            @(posedge clock);
            #1;
            rsp2_valid = acc2;
            rsp2_data  = memWord(addr2);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic outRdy, input logic redirV,
                                 input logic [63:0] redirPc);
        out_ready      = outRdy;
        redirect_valid = redirV;
        redirect_pc    = redirPc;
    endtask

    // Advance one cycle; invariants are checked at the falling edge.
    task automatic tick();
        @(negedge clock);
        if (reset) begin
            checkOutput("occupancy_le_depth",
                        64'((int'(dut.queue_count) + int'(dut.outstanding_q)) <= DEPTH), 64'd1);
            checkOutput("no_push_when_full", 64'(dut.queue_push && dut.queue_full), 64'd0);
        end
        @(posedge clock);
        #1;
    endtask

    // Hold reset for two cycles; the caller releases it in the next cycle.
    task automatic holdReset();
        reset = 1'b0;
        tick();
        tick();
        reqBase = reqCount;
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        req2_ready     = 1'b1;
        redir2_valid   = 1'b0;
        redir2_pc      = '0;
        out2_ready     = 1'b1;
        memLat         = 1;
        applyStimulus(1'b1, 1'b0, 64'h0);

        // Reset state
        tick();
        tick();
        #2;
        checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("rst_req_addr", imem_req_addr, 64'h0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_pc", out_pc, 64'h0);
        checkOutput("rst_out_instr", 64'(out_instr), 64'h0);
        checkOutput("rst_out_pc_link", out_pc_link, 64'h0);
        checkOutput("rst2_req_addr", req2_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        checkOutput("rst2_out_valid", 64'(out2_valid), 64'd0);
`ifdef IPF_ALIGN_FAULT_EN
        checkOutput("rst_fault", 64'(fault), 64'd0);
        checkOutput("rst_fault_pc", fault_pc, 64'h0);
`endif

        // Test 1 (and 5 on dut2): streaming with 1-cycle latency
        tick(); reset = 1'b1; #2;
        checkOutput("t1_c0_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("t1_c0_req_addr", imem_req_addr, 64'h0);
        tick(); #2;
        checkOutput("t1_c1_req_addr", imem_req_addr, 64'h4);
        checkOutput("t1_c1_out_valid", 64'(out_valid), 64'd0);
        tick(); #2;
        checkOutput("t1_c2_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_c2_out_pc", out_pc, 64'h0);
        checkOutput("t1_c2_out_link", out_pc_link, 64'h4);
        checkOutput("t1_c2_out_instr", 64'(out_instr), 64'hC0DE_0000);
        checkOutput("t5_c2_out_pc", out2_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        checkOutput("t5_c2_out_instr", 64'(out2_instr), 64'h3F21_FFF8);
        tick(); #2;
        checkOutput("t1_c3_out_pc", out_pc, 64'h4);
        checkOutput("t1_c3_out_link", out_pc_link, 64'h8);
        checkOutput("t5_c3_out_pc", out2_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("t5_c3_out_link", out2_pc_link, 64'h0);
        tick(); #2;
        checkOutput("t1_c4_out_pc", out_pc, 64'h8);
        checkOutput("t1_c4_out_link", out_pc_link, 64'hC);
        checkOutput("t5_c4_out_pc", out2_pc, 64'h0);
        checkOutput("t5_c4_out_link", out2_pc_link, 64'h4);
        tick(); #2;
        checkOutput("t1_c5_out_pc", out_pc, 64'hC);
        checkOutput("t1_c5_out_link", out_pc_link, 64'h10);

        // Test 2: decode stalled, credit limit reached
        applyStimulus(1'b0, 1'b0, 64'h0);
        holdReset();
        tick(); reset = 1'b1;
        tick(); tick(); tick(); tick(); #2;
        checkOutput("t2_c4_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("t2_c4_out_pc", out_pc, 64'h0);
        tick(); tick(); tick(); #2;
        checkOutput("t2_c7_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_c7_out_pc", out_pc, 64'h0);
        checkOutput("t2_c7_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("t2_c7_req_count", 64'(reqCount - reqBase), 64'd4);
        tick(); applyStimulus(1'b1, 1'b0, 64'h0); #2;
        checkOutput("t2_c8_out_pc", out_pc, 64'h0);
        checkOutput("t2_c8_req_valid", 64'(imem_req_valid), 64'd0);
        tick(); #2;
        checkOutput("t2_c9_out_pc", out_pc, 64'h4);
        checkOutput("t2_c9_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("t2_c9_req_addr", imem_req_addr, 64'h10);
        tick(); #2;
        checkOutput("t2_c10_out_pc", out_pc, 64'h8);
        tick(); #2;
        checkOutput("t2_c11_out_pc", out_pc, 64'hC);
        tick(); #2;
        checkOutput("t2_c12_out_pc", out_pc, 64'h10);

        // Test 3: latency 3, redirect with two requests in flight
        applyStimulus(1'b1, 1'b0, 64'h0);
        holdReset();
        memLat = 3;
        tick(); reset = 1'b1;
        tick();
        tick(); applyStimulus(1'b1, 1'b1, 64'h1000); #2;
        checkOutput("t3_r_req_valid", 64'(imem_req_valid), 64'd0);
        tick(); applyStimulus(1'b1, 1'b0, 64'h0); #2;
        checkOutput("t3_r1_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("t3_r1_req_addr", imem_req_addr, 64'h1000);
        checkOutput("t3_r1_out_valid", 64'(out_valid), 64'd0);
        tick(); #2;
        checkOutput("t3_r2_out_valid", 64'(out_valid), 64'd0);
        tick(); #2;
        checkOutput("t3_r3_out_valid", 64'(out_valid), 64'd0);
        tick(); #2;
        checkOutput("t3_r4_out_valid", 64'(out_valid), 64'd0);
        tick(); #2;
        checkOutput("t3_r5_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t3_r5_out_pc", out_pc, 64'h1000);
        checkOutput("t3_r5_out_instr", 64'(out_instr), 64'hC0DE_1000);
        tick(); #2;
        checkOutput("t3_r6_out_pc", out_pc, 64'h1004);

        // Test 4: redirect coinciding with a response and a pop
        holdReset();
        memLat = 1;
        tick(); reset = 1'b1;
        tick();
        tick(); applyStimulus(1'b1, 1'b1, 64'h2000); #2;
        checkOutput("t4_r_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t4_r_out_pc", out_pc, 64'h0);
        checkOutput("t4_r_req_valid", 64'(imem_req_valid), 64'd0);
        tick(); applyStimulus(1'b1, 1'b0, 64'h0); #2;
        checkOutput("t4_r1_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t4_r1_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("t4_r1_req_addr", imem_req_addr, 64'h2000);
        tick(); #2;
        checkOutput("t4_r2_out_valid", 64'(out_valid), 64'd0);
        tick(); #2;
        checkOutput("t4_r3_out_pc", out_pc, 64'h2000);
        checkOutput("t4_r3_out_instr", 64'(out_instr), 64'hC0DE_2000);

        // Test 6: misaligned redirect
        holdReset();
        tick(); reset = 1'b1;
        tick(); applyStimulus(1'b1, 1'b1, 64'h1002); #2;
        checkOutput("t6_r_req_valid", 64'(imem_req_valid), 64'd0);
        tick(); applyStimulus(1'b1, 1'b0, 64'h0); #2;
`ifdef IPF_ALIGN_FAULT_EN
        checkOutput("t6_fault", 64'(fault), 64'd1);
        checkOutput("t6_fault_pc", fault_pc, 64'h1002);
        checkOutput("t6_r1_req_valid", 64'(imem_req_valid), 64'd0);
        tick(); #2;
        checkOutput("t6_r2_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("t6_r2_out_valid", 64'(out_valid), 64'd0);
`else
        checkOutput("t6_r1_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("t6_r1_req_addr", imem_req_addr, 64'h1000);
        tick();
        tick(); #2;
        checkOutput("t6_r3_out_pc", out_pc, 64'h1000);
        checkOutput("t6_r3_out_instr", 64'(out_instr), 64'hC0DE_1000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
